pc_gen: RTL and testbench

Parametrised program-counter generator for the RISC-V core's fetch stage, replacing the fixed 32-bit, three-mode PC counter. Adds reset vector, trap redirect, redirect buffering while fetch is stalled, misaligned-target detection and a small return-address stack (RAS) for `ret`. It sits between the EX-stage redirect logic and the instruction-memory address port; `PCOutput` drives fetch.

---
 rtl/pc_pkg.sv | 25 ++
 rtl/return_stack.sv | 44 ++++
 rtl/pc_gen.sv | 151 +++++++++++++++
 tb/tb_pc_gen.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage program-counter generator.
package pc_pkg;

    typedef enum logic [2:0] {
        SEQ    = 3'b000,
        BRANCH = 3'b001,
        JALR   = 3'b011,
        RET    = 3'b100
    } pc_sel_t;

    localparam int unsigned INSN_BYTES = 4;

    // Target and return address live beside this struct so they can follow XLEN.
    typedef struct packed {
        logic valid;
        logic is_trap;
        logic push;
        logic pop;
    } pend_ctl_t;

    function automatic logic is_redirect(input logic [2:0] sel);
        return (sel == BRANCH) || (sel == JALR) || (sel == RET);
    endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module return_stack #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [XLEN-1:0]              push_data,
    output logic [XLEN-1:0]              top,
    output logic [$clog2(RAS_DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   top_idx;

    assign top_idx = wr_ptr - PW'(1);
    assign top     = mem[top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PW'(1);
            if (count != CW'(RAS_DEPTH)) begin
                count <= count + CW'(1);
            end
        end else if (pop && (count != '0)) begin
            wr_ptr <= wr_ptr - PW'(1);
            count  <= count - CW'(1);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: redirect priority, stall buffering, misalign rejection and RAS.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [2:0]                  TypeInstruction,
    input  logic                        ras_push,
    input  logic [XLEN-1:0]             pc_EX,
    input  logic [XLEN-1:0]             imm,
    input  logic [XLEN-1:0]             rs1,
    input  logic                        trap_valid,
    input  logic [XLEN-1:0]             trap_vector,
    output logic [XLEN-1:0]             PCOutput,
    output logic                        misalign_valid,
    output logic [XLEN-1:0]             misalign_addr,
    output logic [$clog2(RAS_DEPTH):0]  ras_count
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ras_top;
    logic [XLEN-1:0] seq_target;
    logic [XLEN-1:0] jalr_target;
    logic [XLEN-1:0] cur_target;
    logic [XLEN-1:0] cur_link;
    logic            cur_redirect;
    logic            cur_push;
    logic            cur_pop;

    pend_ctl_t       pend;
    logic [XLEN-1:0] pend_target;
    logic [XLEN-1:0] pend_link;

    logic            apply;
    logic            app_is_trap;
    logic            app_push;
    logic            app_pop;
    logic [XLEN-1:0] app_target;
    logic [XLEN-1:0] app_link;
    logic            misaligned;
    logic            stack_push;
    logic            stack_pop;

    assign PCOutput     = pc;
    assign seq_target   = pc + XLEN'(INSN_BYTES);
    assign jalr_target  = (rs1 + imm) & ~XLEN'(1);
    assign cur_link     = pc_EX + XLEN'(INSN_BYTES);
    assign cur_redirect = is_redirect(TypeInstruction);

    always_comb begin
        cur_target = jalr_target;
        cur_push   = 1'b0;
        cur_pop    = 1'b0;
        case (TypeInstruction)
            BRANCH: begin
                cur_target = pc_EX + imm;
                cur_push   = ras_push;
            end
            JALR: cur_push = ras_push;
            RET: begin
                if (ras_count != '0) begin
                    cur_target = ras_top;
                    cur_pop    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Priority: live trap, then buffered redirect, then the current select.
    always_comb begin
        apply       = 1'b0;
        app_is_trap = 1'b0;
        app_push    = 1'b0;
        app_pop     = 1'b0;
        app_target  = cur_target;
        app_link    = cur_link;
        if (trap_valid) begin
            apply       = 1'b1;
            app_is_trap = 1'b1;
            app_target  = trap_vector;
        end else if (pend.valid) begin
            apply       = 1'b1;
            app_is_trap = pend.is_trap;
            app_push    = pend.push;
            app_pop     = pend.pop;
            app_target  = pend_target;
            app_link    = pend_link;
        end else if (cur_redirect) begin
            apply    = 1'b1;
            app_push = cur_push;
            app_pop  = cur_pop;
        end
    end

    assign misaligned = apply && !app_is_trap && (app_target[1:0] != 2'b00);
    assign stack_push = en && apply && !misaligned && !app_is_trap && app_push;
    assign stack_pop  = en && apply && !misaligned && !app_is_trap && app_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_VECTOR;
            pend           <= '0;
            pend_target    <= '0;
            pend_link      <= '0;
            misalign_valid <= 1'b0;
            misalign_addr  <= '0;
        end else begin
            misalign_valid <= 1'b0;
            if (en) begin
                pend <= '0;
                if (apply) begin
                    if (misaligned) begin
                        misalign_valid <= 1'b1;
                        misalign_addr  <= app_target;
                    end else begin
                        pc <= app_target;
                    end
                end else if (TypeInstruction == SEQ) begin
                    pc <= seq_target;
                end
            end else if (trap_valid) begin
                pend        <= '{valid: 1'b1, is_trap: 1'b1, push: 1'b0, pop: 1'b0};
                pend_target <= trap_vector;
            end else if (cur_redirect && !(pend.valid && pend.is_trap)) begin
                pend        <= '{valid: 1'b1, is_trap: 1'b0, push: cur_push, pop: cur_pop};
                pend_target <= cur_target;
                pend_link   <= cur_link;
            end
        end
    end

    return_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (stack_push),
        .pop       (stack_pop),
        .push_data (app_link),
        .top       (ras_top),
        .count     (ras_count)
    );

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen with RESET_VECTOR=0x100 and a 4-entry return stack.
module tb_pc_gen;
    import pc_pkg::*;

    typedef struct {
        logic        en;
        logic [2:0]  sel;
        logic        push;
        logic [31:0] pc_ex;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic        trap;
        logic [31:0] tv;
        logic [31:0] pc;
        logic        mv;
        logic [31:0] ma;
        logic [2:0]  cnt;
    } step_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [2:0]  TypeInstruction = 3'b000;
    logic        ras_push = 1'b0;
    logic [31:0] pc_EX = '0;
    logic [31:0] imm = '0;
    logic [31:0] rs1 = '0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_vector = '0;
    logic [31:0] PCOutput;
    logic        misalign_valid;
    logic [31:0] misalign_addr;
    logic [2:0]  ras_count;

    int errors = 0;
    int checks = 0;
    step_t exp_q[$];

    pc_gen #(
        .XLEN         (32),
        .RESET_VECTOR (32'h100),
        .RAS_DEPTH    (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .TypeInstruction (TypeInstruction),
        .ras_push        (ras_push),
        .pc_EX           (pc_EX),
        .imm             (imm),
        .rs1             (rs1),
        .trap_valid      (trap_valid),
        .trap_vector     (trap_vector),
        .PCOutput        (PCOutput),
        .misalign_valid  (misalign_valid),
        .misalign_addr   (misalign_addr),
        .ras_count       (ras_count)
    );

    always #5 clk = ~clk;

    function automatic step_t mk(input logic e, input logic [2:0] s, input logic p,
                                 input logic [31:0] pe, input logic [31:0] im,
                                 input logic [31:0] r, input logic t, input logic [31:0] v,
                                 input logic [31:0] xpc, input logic xmv,
                                 input logic [31:0] xma, input logic [2:0] xcnt);
        step_t s_out;
        s_out.en = e;     s_out.sel = s;  s_out.push = p;  s_out.pc_ex = pe;
        s_out.imm = im;   s_out.rs1 = r;  s_out.trap = t;  s_out.tv = v;
        s_out.pc = xpc;   s_out.mv = xmv; s_out.ma = xma;  s_out.cnt = xcnt;
        return s_out;
    endfunction

    task automatic drive(input step_t s);
        en = s.en;
        TypeInstruction = s.sel;
        ras_push = s.push;
        pc_EX = s.pc_ex;
        imm = s.imm;
        rs1 = s.rs1;
        trap_valid = s.trap;
        trap_vector = s.tv;
        exp_q.push_back(s);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #2;
        checks++; if (PCOutput !== 32'h100) begin errors++; $display("FAIL reset pc: got %h want %h", PCOutput, 32'h100); end
        checks++; if (misalign_valid !== 1'b0) begin errors++; $display("FAIL reset misalign_valid: got %b want 0", misalign_valid); end
        checks++; if (misalign_addr !== 32'h0) begin errors++; $display("FAIL reset misalign_addr: got %h want 0", misalign_addr); end
        checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL reset ras_count: got %0d want 0", ras_count); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_seq_jalr();
        step_t t[$];
        step_t e;
        t.push_back(mk(1, SEQ,    0, 0, 0,     0,       0, 0, 32'h104,  0, 0,       0));
        t.push_back(mk(1, SEQ,    0, 0, 0,     0,       0, 0, 32'h108,  0, 0,       0));
        t.push_back(mk(1, SEQ,    0, 0, 0,     0,       0, 0, 32'h10C,  0, 0,       0));
        t.push_back(mk(1, JALR,   0, 0, 32'h10, 32'h2001, 0, 0, 32'h2010, 0, 0,       0));
        t.push_back(mk(1, JALR,   0, 0, 0,     32'h2002, 0, 0, 32'h2010, 1, 32'h2002, 0));
        t.push_back(mk(1, SEQ,    0, 0, 0,     0,       0, 0, 32'h2014, 0, 0,       0));
        t.push_back(mk(1, 3'b010, 0, 0, 0,     0,       0, 0, 32'h2014, 0, 0,       0));
        t.push_back(mk(1, 3'b111, 0, 0, 0,     0,       0, 0, 32'h2014, 0, 0,       0));
        foreach (t[i]) begin
            drive(t[i]);
            e = exp_q.pop_front();
            checks++; if (PCOutput !== e.pc) begin errors++; $display("FAIL seq_jalr[%0d] pc: got %h want %h", i, PCOutput, e.pc); end
            checks++; if (misalign_valid !== e.mv) begin errors++; $display("FAIL seq_jalr[%0d] misalign_valid: got %b want %b", i, misalign_valid, e.mv); end
            checks++; if (ras_count !== e.cnt) begin errors++; $display("FAIL seq_jalr[%0d] ras_count: got %0d want %0d", i, ras_count, e.cnt); end
            if (e.mv) begin
                checks++; if (misalign_addr !== e.ma) begin errors++; $display("FAIL seq_jalr[%0d] misalign_addr: got %h want %h", i, misalign_addr, e.ma); end
            end
        end
    endtask

    task automatic test_stall_branch();
        step_t t[$];
        step_t e;
        t.push_back(mk(0, BRANCH, 0, 32'h40, 32'h20, 0, 0, 0, 32'h2014, 0, 0, 0));
        t.push_back(mk(0, SEQ,    0, 0,      0,      0, 0, 0, 32'h2014, 0, 0, 0));
        t.push_back(mk(0, SEQ,    0, 0,      0,      0, 0, 0, 32'h2014, 0, 0, 0));
        t.push_back(mk(1, SEQ,    0, 0,      0,      0, 0, 0, 32'h60,   0, 0, 0));
        t.push_back(mk(1, SEQ,    0, 0,      0,      0, 0, 0, 32'h64,   0, 0, 0));
        foreach (t[i]) begin
            drive(t[i]);
            e = exp_q.pop_front();
            checks++; if (PCOutput !== e.pc) begin errors++; $display("FAIL stall[%0d] pc: got %h want %h", i, PCOutput, e.pc); end
            checks++; if (misalign_valid !== e.mv) begin errors++; $display("FAIL stall[%0d] misalign_valid: got %b want %b", i, misalign_valid, e.mv); end
            checks++; if (ras_count !== e.cnt) begin errors++; $display("FAIL stall[%0d] ras_count: got %0d want %0d", i, ras_count, e.cnt); end
        end
    endtask

    task automatic test_trap();
        step_t t[$];
        step_t e;
        t.push_back(mk(0, BRANCH, 0, 32'h100, 32'h10, 0, 0, 0,       32'h64,  0, 0, 0));
        t.push_back(mk(0, SEQ,    0, 0,       0,      0, 1, 32'h800, 32'h64,  0, 0, 0));
        t.push_back(mk(0, BRANCH, 0, 32'h300, 0,      0, 0, 0,       32'h64,  0, 0, 0));
        t.push_back(mk(1, SEQ,    0, 0,       0,      0, 0, 0,       32'h800, 0, 0, 0));
        t.push_back(mk(1, SEQ,    0, 0,       0,      0, 0, 0,       32'h804, 0, 0, 0));
        t.push_back(mk(0, BRANCH, 0, 32'h200, 0,      0, 0, 0,       32'h804, 0, 0, 0));
        t.push_back(mk(1, BRANCH, 0, 32'h400, 0,      0, 1, 32'h900, 32'h900, 0, 0, 0));
        foreach (t[i]) begin
            drive(t[i]);
            e = exp_q.pop_front();
            checks++; if (PCOutput !== e.pc) begin errors++; $display("FAIL trap[%0d] pc: got %h want %h", i, PCOutput, e.pc); end
            checks++; if (misalign_valid !== e.mv) begin errors++; $display("FAIL trap[%0d] misalign_valid: got %b want %b", i, misalign_valid, e.mv); end
            checks++; if (ras_count !== e.cnt) begin errors++; $display("FAIL trap[%0d] ras_count: got %0d want %0d", i, ras_count, e.cnt); end
        end
    endtask

    task automatic test_ras();
        step_t t[$];
        step_t e;
        logic [31:0] ret_pc [4];
        ret_pc[0] = 32'h54; ret_pc[1] = 32'h44; ret_pc[2] = 32'h34; ret_pc[3] = 32'h24;
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            t.push_back(mk(1, BRANCH, 1, 32'(16 * k), 32'h1000, 0, 0, 0,
                           32'h1000 + 32'(16 * k), 0, 0, 3'((k < 4) ? k : 4)));
        end
        for (int k = 0; k < 4; k++) begin
            t.push_back(mk(1, RET, 0, 0, 0, 0, 0, 0, ret_pc[k], 0, 0, 3'(3 - k)));
        end
        t.push_back(mk(1, RET, 0, 0, 0, 32'h900, 0, 0, 32'h900, 0, 0, 0));
        foreach (t[i]) begin
            drive(t[i]);
            e = exp_q.pop_front();
            checks++; if (PCOutput !== e.pc) begin errors++; $display("FAIL ras[%0d] pc: got %h want %h", i, PCOutput, e.pc); end
            checks++; if (misalign_valid !== e.mv) begin errors++; $display("FAIL ras[%0d] misalign_valid: got %b want %b", i, misalign_valid, e.mv); end
            checks++; if (ras_count !== e.cnt) begin errors++; $display("FAIL ras[%0d] ras_count: got %0d want %0d", i, ras_count, e.cnt); end
        end
    endtask

    task automatic test_reset_mid_stall();
        step_t t[$];
        step_t e;
        t.push_back(mk(1, JALR,   1, 32'h10,  32'h500, 0,       0, 0, 32'h500, 0, 0, 1));
        t.push_back(mk(1, JALR,   1, 32'h20,  0,       32'h600, 0, 0, 32'h600, 0, 0, 2));
        t.push_back(mk(0, BRANCH, 1, 32'h300, 0,       0,       0, 0, 32'h600, 0, 0, 2));
        foreach (t[i]) begin
            drive(t[i]);
            e = exp_q.pop_front();
            checks++; if (PCOutput !== e.pc) begin errors++; $display("FAIL midrst[%0d] pc: got %h want %h", i, PCOutput, e.pc); end
            checks++; if (ras_count !== e.cnt) begin errors++; $display("FAIL midrst[%0d] ras_count: got %0d want %0d", i, ras_count, e.cnt); end
        end
        rst_n = 1'b0;
        #2;
        checks++; if (PCOutput !== 32'h100) begin errors++; $display("FAIL midrst pc_in_reset: got %h want %h", PCOutput, 32'h100); end
        checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL midrst count_in_reset: got %0d want 0", ras_count); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(mk(1, SEQ, 0, 0, 0, 0, 0, 0, 32'h104, 0, 0, 0));
        e = exp_q.pop_front();
        checks++; if (PCOutput !== e.pc) begin errors++; $display("FAIL midrst first_seq pc: got %h want %h", PCOutput, e.pc); end
        checks++; if (ras_count !== e.cnt) begin errors++; $display("FAIL midrst first_seq ras_count: got %0d want %0d", ras_count, e.cnt); end
        checks++; if (misalign_valid !== e.mv) begin errors++; $display("FAIL midrst first_seq misalign_valid: got %b want %b", misalign_valid, e.mv); end
    endtask

    initial begin
        test_reset();
        test_seq_jalr();
        test_stall_branch();
        test_trap();
        test_ras();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
